periph_gpio: RTL
================

PERIPH_GPIO -- requirements
Module: periph_gpio

Interface
REQ-001 SHALL have parameter NUM_OUT, default 3: output pin count, 1..32.
REQ-002 SHALL have parameter NUM_IN, default 1: input pin count, 1..24.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: stability window in clk cycles; 0 bypasses debounce.
REQ-004 SHALL have parameter OUT_ACTIVE_LOW, default 1: 1 drives inverted pins (LEDs).
REQ-005 SHALL have parameter STATUS_FLAGS, default 8'h00: constant platform flags, returned in STATUS[31:24].
REQ-006 SHALL have port clk  in  1  sole clock.
REQ-007 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port cmd_valid  in  1  dBus command already decoded to this block's region.
REQ-009 SHALL have port cmd_ready  out  1  constant 1.
REQ-010 SHALL have port cmd_wr  in  1  1 = write, 0 = read.
REQ-011 SHALL have port cmd_address  in  12  byte offset within region.
REQ-012 SHALL have port cmd_data  in  32  write data.
REQ-013 SHALL have port cmd_size  in  2  0 byte, 1 half, 2 word.
REQ-014 SHALL have port rsp_valid  out  1  read data valid.
REQ-015 SHALL have port rsp_data  out  32  read data.
REQ-016 SHALL have port gpio_out  out  NUM_OUT  output pins.
REQ-017 SHALL have port gpio_in  in  NUM_IN  asynchronous input pins.
REQ-018 SHALL have port irq  out  1  level interrupt.

Function
REQ-019 SHALL decode registers on address[11:2]: 0x000 OUT rw, 0x004 STATUS ro, 0x008 EDGE w1c, 0x00C IRQ_EN rw, 0x010 OUT_SET wo, 0x014 OUT_CLR wo.
REQ-020 SHALL derive byte enables: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; else 4'b1111; all writes honour enabled lanes only.
REQ-021 SHALL assert rsp_valid for exactly one cycle, the cycle after each accepted read; no response for writes.
REQ-022 SHALL return 0 for unmapped or write-only offsets, ignore writes to unmapped/read-only offsets; bits above NUM_OUT/NUM_IN read 0.
REQ-023 SHALL hold rsp_data stable when rsp_valid is low.
REQ-024 SHALL drive gpio_out = OUT ^ {NUM_OUT{OUT_ACTIVE_LOW}}, registered.
REQ-025 SHALL apply OUT_SET as OUT |= data, OUT_CLR as OUT &= ~data, within lanes.
REQ-026 SHALL synchronise each gpio_in bit through two flops.
REQ-027 SHALL change a debounced bit only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears that bit's counter.
REQ-028 SHALL set EDGE[i] on a debounced 0->1 transition of input i; same-cycle set and w1c clear -> set wins.
REQ-029 SHALL return STATUS = {STATUS_FLAGS, debounced inputs zero-extended to 24 bits}.
REQ-030 SHALL drive irq = |(EDGE & IRQ_EN), registered (one-cycle latency from EDGE/IRQ_EN update).

Reset
REQ-031 SHALL on reset_n low clear OUT, IRQ_EN, EDGE, synchronisers, debounced state, counters, rsp_valid, rsp_data, irq; gpio_out then equals {NUM_OUT{OUT_ACTIVE_LOW}}.
REQ-032 SHALL abort an outstanding read response on reset mid-operation (rsp_valid low during and after reset).
REQ-033 SHALL treat an input held high through reset as a rising edge after sync+debounce delay.

Structure
REQ-034 SHALL place register offsets and the byte-enable function in package periph_gpio_pkg.
REQ-035 SHALL instantiate one sub-module gpio_debounce per input (sync, counter, debounced bit, rise pulse).

Verification
REQ-036 Write 0x5 word to 0x000, NUM_OUT=3, active-low -> gpio_out=3'b010 next cycle; read 0x000 -> rsp_valid 1 cycle later, data 0x5.
REQ-037 OUT=0x0F; byte write 0xA5 at 0x011 (size 0) -> OUT=0x0F (lane 1 only, OUT[7:0] unchanged); OUT_CLR 0x3 at 0x014 -> OUT=0x0C.
REQ-038 DEBOUNCE_CYCLES=16: gpio_in high 10 cycles then low -> STATUS[0] stays 0, EDGE=0; high 20 cycles -> STATUS[0]=1 exactly 2+16 cycles after rise, EDGE[0]=1.
REQ-039 IRQ_EN=1, rising edge -> irq high one cycle after EDGE set; write 1 to 0x008 -> EDGE=0, irq low next cycle; clear coincident with new edge -> EDGE stays 1.
REQ-040 STATUS_FLAGS=8'h06: read 0x004 -> data[31:24]=0x06; read 0x020 -> 0; reset_n pulsed the cycle after a read -> no rsp_valid, all registers at reset values.

Source files
------------

// File: rtl/periph_gpio_pkg.sv
// periph_gpio_pkg
//   Shared definitions for the GPIO peripheral: register byte offsets within
//   the block's 4 KiB region and helpers that turn a bus access size/offset
//   into byte-lane enables and a 32-bit lane mask.
//   No ports (package).
package periph_gpio_pkg;

    // Register byte offsets; decode compares only address[11:2].
    localparam logic [11:0] OFF_OUT     = 12'h000;
    localparam logic [11:0] OFF_STATUS  = 12'h004;
    localparam logic [11:0] OFF_EDGE    = 12'h008;
    localparam logic [11:0] OFF_IRQ_EN  = 12'h00C;
    localparam logic [11:0] OFF_OUT_SET = 12'h010;
    localparam logic [11:0] OFF_OUT_CLR = 12'h014;

    // Access size encoding on the command bus.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    // Byte enables for an access. A halfword at offset 3 shifts its upper
    // lane out of the word, leaving only lane 3 enabled.
    function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                               input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = 4'b0011 << offset;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Expand byte enables to a bit mask over the 32-bit data word.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/periph_gpio_debounce.sv
// gpio_debounce
//   One asynchronous input pin: two-flop synchroniser, per-bit stability
//   counter, debounced level and a single-cycle rise pulse.
//   Ports:
//     clk     in   sole clock
//     reset_n in   asynchronous active-low reset
//     pin     in   raw asynchronous input
//     level   out  debounced level (registered)
//     rise    out  high for the cycle in which level is about to go 0->1,
//                  so a consumer sampling it updates on the same edge as level
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;

    // Two flops bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass

        // No stability window: the level simply follows the synchroniser.
        assign rise = sync & ~level;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level <= 1'b0;
            end else begin
                level <= sync;
            end
        end

    end else begin : g_filter

        localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

        logic [CNT_W-1:0] count;
        logic             expire;

        // The counter holds how many consecutive disagreeing cycles have
        // already been seen; this cycle is the last one of the window when
        // it still disagrees and count has reached DEBOUNCE_CYCLES-1.
        assign expire = (sync != level) && (count == CNT_W'(DEBOUNCE_CYCLES - 1));
        assign rise   = expire & sync;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                level <= 1'b0;
                count <= '0;
            end else if (sync == level) begin
                count <= '0;
            end else if (expire) begin
                level <= sync;
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end

    end

endmodule

// File: rtl/periph_gpio.sv
// periph_gpio
//   Memory-mapped GPIO block on the decoded dBus: output register with
//   set/clear aliases, debounced inputs with rising-edge capture, and a
//   level interrupt.
//   Ports:
//     clk, reset_n                 clock, asynchronous active-low reset
//     cmd_valid/ready/wr/address/data/size   command (ready is always 1)
//     rsp_valid, rsp_data          read response, one cycle after the read
//     gpio_out [NUM_OUT]           output pins, optionally inverted
//     gpio_in  [NUM_IN]            asynchronous input pins
//     irq                          level interrupt, |(EDGE & IRQ_EN) registered
module periph_gpio
    import periph_gpio_pkg::*;
#(
    parameter int         NUM_OUT         = 3,
    parameter int         NUM_IN          = 1,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         OUT_ACTIVE_LOW  = 1,
    parameter logic [7:0] STATUS_FLAGS    = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [11:0]        cmd_address,
    input  logic [31:0]        cmd_data,
    input  logic [1:0]         cmd_size,
    output logic               rsp_valid,
    output logic [31:0]        rsp_data,
    output logic [NUM_OUT-1:0] gpio_out,
    input  logic [NUM_IN-1:0]  gpio_in,
    output logic               irq
);

    localparam logic OUT_POLARITY = (OUT_ACTIVE_LOW != 0);

    logic [NUM_OUT-1:0] out_q;
    logic [NUM_OUT-1:0] out_next;
    logic [NUM_IN-1:0]  irq_en_q;
    logic [NUM_IN-1:0]  irq_en_next;
    logic [NUM_IN-1:0]  edge_q;
    logic [NUM_IN-1:0]  edge_next;
    logic [NUM_IN-1:0]  edge_clear;
    logic [NUM_IN-1:0]  level;
    logic [NUM_IN-1:0]  rise;
    logic [9:0]         word;
    logic [31:0]        mask;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               wr_en;
    logic               rd_en;

    assign cmd_ready = 1'b1;
    assign wr_en     = cmd_valid & cmd_wr;
    assign rd_en     = cmd_valid & ~cmd_wr;
    assign word      = cmd_address[11:2];
    assign mask      = lane_mask(byte_enable(cmd_size, cmd_address[1:0]));
    assign wdata     = cmd_data & mask;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        gpio_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (gpio_in[i]),
            .level  (level[i]),
            .rise   (rise[i])
        );
    end

    // Next register values from the write path; only enabled lanes change.
    always_comb begin
        out_next    = out_q;
        irq_en_next = irq_en_q;
        edge_clear  = '0;
        if (wr_en) begin
            if (word == OFF_OUT[11:2]) begin
                out_next = (out_q & ~mask[NUM_OUT-1:0]) | wdata[NUM_OUT-1:0];
            end else if (word == OFF_OUT_SET[11:2]) begin
                out_next = out_q | wdata[NUM_OUT-1:0];
            end else if (word == OFF_OUT_CLR[11:2]) begin
                out_next = out_q & ~wdata[NUM_OUT-1:0];
            end else if (word == OFF_IRQ_EN[11:2]) begin
                irq_en_next = (irq_en_q & ~mask[NUM_IN-1:0]) | wdata[NUM_IN-1:0];
            end else if (word == OFF_EDGE[11:2]) begin
                edge_clear = wdata[NUM_IN-1:0];
            end
        end
    end

    // A rise in the same cycle as a write-one-to-clear keeps the bit set.
    assign edge_next = (edge_q & ~edge_clear) | rise;

    // Read mux; write-only and unmapped offsets return zero.
    always_comb begin
        rdata = '0;
        if (word == OFF_OUT[11:2]) begin
            rdata = 32'(out_q);
        end else if (word == OFF_STATUS[11:2]) begin
            rdata = {STATUS_FLAGS, 24'(level)};
        end else if (word == OFF_EDGE[11:2]) begin
            rdata = 32'(edge_q);
        end else if (word == OFF_IRQ_EN[11:2]) begin
            rdata = 32'(irq_en_q);
        end
    end

    // Register state; gpio_out is loaded from the next OUT value so the pins
    // change on the same edge as the register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            irq_en_q <= '0;
            edge_q   <= '0;
            gpio_out <= {NUM_OUT{OUT_POLARITY}};
            irq      <= 1'b0;
        end else begin
            out_q    <= out_next;
            irq_en_q <= irq_en_next;
            edge_q   <= edge_next;
            gpio_out <= out_next ^ {NUM_OUT{OUT_POLARITY}};
            irq      <= |(edge_q & irq_en_q);
        end
    end

    // Read response; rsp_data only loads on a read so it holds otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_en;
            if (rd_en) begin
                rsp_data <= rdata;
            end
        end
    end

endmodule
